conv_processor_sequencer: RTL and testbench

CONV_PROCESSOR_SEQUENCER -- requirements
Module: conv_processor_sequencer

---
 rtl/conv_processor_pkg.sv | 16 +
 rtl/conv_seq_loop_counter.sv | 45 ++++
 rtl/conv_processor_sequencer.sv | 116 +++++++++++
 tb/tb_conv_processor_sequencer.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_processor_pkg.sv
// Shared definitions for the convolution sequencer: FSM encoding and default
// operand address width.
package conv_processor_pkg;

  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MAC   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/conv_seq_loop_counter.sv
// Loop counter with a latched terminal value: load captures the terminal and
// zeroes the count, clr zeroes the count, inc steps it; tc_o flags count==terminal.
module conv_seq_loop_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] term_q, term_d;

  always_comb begin
    cnt_d  = cnt_q;
    term_d = term_q;
    if (load_i) begin
      cnt_d  = '0;
      term_d = term_i;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      term_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_q);

endmodule

// File: rtl/conv_processor_sequencer.sv
// Control sequencer for a direct-form 1-D convolution Z = X * Y: walks output
// index i and tap index j, drives X/Y read addresses, accumulator controls and Z writes.
module conv_processor_sequencer
  import conv_processor_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int SIZE_W = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE_W-1:0] size_x,
  input  logic [SIZE_W-1:0] size_y,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_x_addr,
  output logic [ADDR_W-1:0] mem_y_addr,
  output logic [ADDR_W:0]   mem_z_addr,
  output logic              mem_z_we,
  output logic              acc_clear,
  output logic              acc_load
);

  localparam int IW = ADDR_W + 1;   // output index spans 0..2^(ADDR_W+1)-2
  localparam int DW = ADDR_W + 2;   // signed width for the i-j window test

  state_e state_q, state_d;

  logic [SIZE_W-1:0] size_x_q, size_x_d;
  logic              acc_load_q;

  logic              accept;
  logic              zero_run;
  logic [SIZE_W:0]   nz_m1;
  logic [IW-1:0]     i_cnt;
  logic              i_tc;
  logic [SIZE_W-1:0] j_cnt;
  logic              j_tc;

  logic signed [DW-1:0] diff;
  logic signed [DW-1:0] x_lim;
  logic                 rd_valid;

  assign accept   = (state_q == ST_IDLE) && start;
  assign zero_run = (size_x == '0) || (size_y == '0);
  assign nz_m1    = {1'b0, size_x} + {1'b0, size_y} - (SIZE_W + 1)'(2);

  // Terminal counts are captured at accept, so later size changes are invisible.
  conv_seq_loop_counter #(.W(IW)) u_i_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .clr_i  (1'b0),
    .inc_i  ((state_q == ST_WRITE) && !i_tc),
    .term_i (IW'(nz_m1)),
    .cnt_o  (i_cnt),
    .tc_o   (i_tc)
  );

  conv_seq_loop_counter #(.W(SIZE_W)) u_j_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .clr_i  (state_q == ST_CLEAR),
    .inc_i  (state_q == ST_MAC),
    .term_i (size_y - SIZE_W'(1)),
    .cnt_o  (j_cnt),
    .tc_o   (j_tc)
  );

  assign diff     = signed'(DW'(i_cnt)) - signed'(DW'(j_cnt));
  assign x_lim    = signed'(DW'(size_x_q)) - signed'(DW'(1));
  assign rd_valid = (state_q == ST_MAC) && !diff[DW-1] && (diff <= x_lim);

  always_comb begin
    state_d  = state_q;
    size_x_d = size_x_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          size_x_d = size_x;
          state_d  = zero_run ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_MAC;
      ST_MAC:   if (j_tc) state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_WRITE;
      ST_WRITE: state_d = i_tc ? ST_DONE : ST_CLEAR;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // acc_load trails rd_valid by one cycle to meet the 1-cycle memory read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      size_x_q   <= '0;
      acc_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_x_q   <= size_x_d;
      acc_load_q <= rd_valid;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign mem_z_we   = (state_q == ST_WRITE);
  assign acc_clear  = (state_q == ST_CLEAR);
  assign acc_load   = acc_load_q;
  assign mem_y_addr = (state_q == ST_MAC)   ? ADDR_W'(j_cnt)      : '0;
  assign mem_x_addr = (state_q == ST_MAC)   ? diff[ADDR_W-1:0]    : '0;
  assign mem_z_addr = (state_q == ST_WRITE) ? i_cnt               : '0;

endmodule

// File: tb/tb_conv_processor_sequencer.sv
// Bench for conv_processor_sequencer: behavioural X/Y memories and accumulator,
// reference convolution pushed to a scoreboard at start, compared against Z writes.
module tb_conv_processor_sequencer;

  localparam int AW = 5;
  localparam int SW = AW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] size_x = '0;
  logic [SW-1:0] size_y = '0;
  logic          busy, done, mem_z_we, acc_clear, acc_load;
  logic [AW-1:0] mem_x_addr, mem_y_addr;
  logic [AW:0]   mem_z_addr;

  conv_processor_sequencer #(.ADDR_W(AW), .SIZE_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .size_x     (size_x),
    .size_y     (size_y),
    .busy       (busy),
    .done       (done),
    .mem_x_addr (mem_x_addr),
    .mem_y_addr (mem_y_addr),
    .mem_z_addr (mem_z_addr),
    .mem_z_we   (mem_z_we),
    .acc_clear  (acc_clear),
    .acc_load   (acc_load)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memories (1-cycle read) and accumulator, clear over load.
  int xmem [32];
  int ymem [32];
  int x_rd = 0, y_rd = 0, acc = 0;

  always @(posedge clk) begin
    x_rd <= xmem[mem_x_addr];
    y_rd <= ymem[mem_y_addr];
    if (acc_clear)     acc <= 0;
    else if (acc_load) acc <= acc + x_rd * y_rd;
  end

  // Monitor: records Z writes, load pulses and done timing.
  int wr_cnt = 0, ld_cnt = 0, done_cnt = 0, done_abs = 0;
  int obs_addr [512];
  int obs_val  [512];

  always @(negedge clk) begin
    if (acc_load) ld_cnt <= ld_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_abs <= cyc;
    end
    if (mem_z_we && wr_cnt < 512) begin
      obs_addr[wr_cnt] <= int'(mem_z_addr);
      obs_val[wr_cnt]  <= acc;
      wr_cnt           <= wr_cnt + 1;
    end
  end

  typedef struct { int addr; int val; } zexp_t;
  zexp_t sb [$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_expected(input int sx, input int sy, input int nmax);
    int nz;
    nz = sx + sy - 1;
    for (int i = 0; i < nz && i < nmax; i++) begin
      zexp_t e;
      int s;
      s = 0;
      for (int j = 0; j < sy; j++)
        if (i - j >= 0 && i - j < sx) s += xmem[i-j] * ymem[j];
      e.addr = i;
      e.val  = s;
      sb.push_back(e);
    end
  endtask

  // Drives a one-cycle start; returns #1 after the accepting edge (cycle 1).
  task automatic do_start(input int sx, input int sy);
    size_x    = SW'(sx);
    size_y    = SW'(sy);
    start     = 1'b1;
    start_cyc = cyc + 1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic load_basic();
    for (int k = 0; k < 32; k++) begin
      xmem[k] = 0;
      ymem[k] = 0;
    end
    xmem[0] = 1; xmem[1] = 2; xmem[2] = 3;
    ymem[0] = 1; ymem[1] = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    n_chk++;
    if ({busy, done, mem_z_we, acc_clear, acc_load} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, expected 00000", {busy, done, mem_z_we, acc_clear, acc_load});
    end
    n_chk++;
    if ({mem_x_addr, mem_y_addr, mem_z_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_addrs: x=%0d y=%0d z=%0d, expected all 0", mem_x_addr, mem_y_addr, mem_z_addr);
    end
    size_x = SW'(3);
    size_y = SW'(2);
    start  = 1'b1;
    tick(1);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_over_start: busy=%b, expected 0", busy);
    end
    start = 1'b0;
    rst   = 1'b0;
    tick(1);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_basic();
    int w0, l0, d0;
    bit ok;
    load_basic();
    w0 = wr_cnt; l0 = ld_cnt; d0 = done_cnt;
    push_expected(3, 2, 100);
    do_start(3, 2);
    size_x = SW'(7);
    size_y = SW'(9);
    wait_done(d0, 200, ok);
    tick(3);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_timeout: done not seen within 200 cycles, expected cycle 21");
    end
    n_chk++;
    if (done_abs - start_cyc + 1 !== 21) begin
      n_fail++;
      $display("FAIL basic_done_cycle: got %0d, expected 21", done_abs - start_cyc + 1);
    end
    n_chk++;
    if (ld_cnt - l0 !== 6) begin
      n_fail++;
      $display("FAIL basic_load_count: got %0d, expected 6", ld_cnt - l0);
    end
    for (int k = w0; k < wr_cnt; k++) begin
      zexp_t e;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL basic_z_extra: addr %0d val %0d, expected no write", obs_addr[k], obs_val[k]);
      end else begin
        e = sb.pop_front();
        if (obs_addr[k] !== e.addr || obs_val[k] !== e.val) begin
          n_fail++;
          $display("FAIL basic_z: addr %0d val %0d, expected addr %0d val %0d", obs_addr[k], obs_val[k], e.addr, e.val);
        end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL basic_z_missing: %0d writes outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_single();
    int w0, l0, d0;
    bit ok;
    xmem[0] = 5;
    ymem[0] = 7;
    w0 = wr_cnt; l0 = ld_cnt; d0 = done_cnt;
    push_expected(1, 1, 100);
    do_start(1, 1);
    wait_done(d0, 50, ok);
    tick(3);
    n_chk++;
    if (!ok || done_abs - start_cyc + 1 !== 5) begin
      n_fail++;
      $display("FAIL single_done_cycle: got %0d (seen=%0b), expected 5", done_abs - start_cyc + 1, ok);
    end
    n_chk++;
    if (ld_cnt - l0 !== 1) begin
      n_fail++;
      $display("FAIL single_load_count: got %0d, expected 1", ld_cnt - l0);
    end
    for (int k = w0; k < wr_cnt; k++) begin
      zexp_t e;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL single_z_extra: addr %0d val %0d, expected no write", obs_addr[k], obs_val[k]);
      end else begin
        e = sb.pop_front();
        if (obs_addr[k] !== e.addr || obs_val[k] !== e.val) begin
          n_fail++;
          $display("FAIL single_z: addr %0d val %0d, expected addr %0d val %0d", obs_addr[k], obs_val[k], e.addr, e.val);
        end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL single_z_missing: %0d writes outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_zero();
    int w0, l0, d0;
    bit ok;
    int sxs [2];
    int sys [2];
    sxs[0] = 0; sys[0] = 4;
    sxs[1] = 4; sys[1] = 0;
    for (int t = 0; t < 2; t++) begin
      w0 = wr_cnt; l0 = ld_cnt; d0 = done_cnt;
      do_start(sxs[t], sys[t]);
      wait_done(d0, 20, ok);
      tick(3);
      n_chk++;
      if (!ok || done_abs - start_cyc + 1 !== 1) begin
        n_fail++;
        $display("FAIL zero_done_cycle[%0d]: got %0d (seen=%0b), expected 1", t, done_abs - start_cyc + 1, ok);
      end
      n_chk++;
      if (wr_cnt - w0 !== 0 || ld_cnt - l0 !== 0) begin
        n_fail++;
        $display("FAIL zero_no_activity[%0d]: writes %0d loads %0d, expected 0 and 0", t, wr_cnt - w0, ld_cnt - l0);
      end
    end
  endtask

  task automatic test_large();
    int w0, l0, d0;
    bit ok;
    for (int k = 0; k < 32; k++) begin
      xmem[k] = int'($urandom_range(15));
      ymem[k] = int'($urandom_range(15));
    end
    w0 = wr_cnt; l0 = ld_cnt; d0 = done_cnt;
    push_expected(32, 32, 100);
    do_start(32, 32);
    wait_done(d0, 3000, ok);
    tick(3);
    n_chk++;
    if (!ok || done_abs - start_cyc + 1 !== 2206) begin
      n_fail++;
      $display("FAIL large_done_cycle: got %0d (seen=%0b), expected 2206", done_abs - start_cyc + 1, ok);
    end
    n_chk++;
    if (wr_cnt - w0 !== 63) begin
      n_fail++;
      $display("FAIL large_write_count: got %0d, expected 63", wr_cnt - w0);
    end
    n_chk++;
    if (wr_cnt > w0 && obs_addr[wr_cnt-1] !== 62) begin
      n_fail++;
      $display("FAIL large_last_addr: got %0d, expected 62", obs_addr[wr_cnt-1]);
    end
    n_chk++;
    if (ld_cnt - l0 !== 1024) begin
      n_fail++;
      $display("FAIL large_load_count: got %0d, expected 1024", ld_cnt - l0);
    end
    for (int k = w0; k < wr_cnt; k++) begin
      zexp_t e;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL large_z_extra: addr %0d val %0d, expected no write", obs_addr[k], obs_val[k]);
      end else begin
        e = sb.pop_front();
        if (obs_addr[k] !== e.addr || obs_val[k] !== e.val) begin
          n_fail++;
          $display("FAIL large_z: addr %0d val %0d, expected addr %0d val %0d", obs_addr[k], obs_val[k], e.addr, e.val);
        end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL large_z_missing: %0d writes outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_midrun();
    int w0, d0;
    bit ok;
    load_basic();
    w0 = wr_cnt;
    push_expected(3, 2, 2);
    do_start(3, 2);
    tick(11);
    n_chk++;
    if (mem_y_addr !== 5'd0 || mem_x_addr !== 5'd2) begin
      n_fail++;
      $display("FAIL midrun_mac_addrs: x=%0d y=%0d, expected x=2 y=0", mem_x_addr, mem_y_addr);
    end
    rst = 1'b1;
    tick(1);
    n_chk++;
    if ({busy, done, mem_z_we, acc_clear, acc_load, mem_x_addr, mem_y_addr, mem_z_addr} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset_outputs: busy=%b done=%b we=%b clr=%b ld=%b x=%0d y=%0d z=%0d, expected all 0",
               busy, done, mem_z_we, acc_clear, acc_load, mem_x_addr, mem_y_addr, mem_z_addr);
    end
    rst = 1'b0;
    tick(6);
    n_chk++;
    if (wr_cnt - w0 !== 2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_aborted: writes %0d busy %b, expected 2 and 0", wr_cnt - w0, busy);
    end
    for (int k = w0; k < wr_cnt; k++) begin
      zexp_t e;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL midrun_z_extra: addr %0d val %0d, expected no write", obs_addr[k], obs_val[k]);
      end else begin
        e = sb.pop_front();
        if (obs_addr[k] !== e.addr || obs_val[k] !== e.val) begin
          n_fail++;
          $display("FAIL midrun_z: addr %0d val %0d, expected addr %0d val %0d", obs_addr[k], obs_val[k], e.addr, e.val);
        end
      end
    end
    sb.delete();
    w0 = wr_cnt; d0 = done_cnt;
    push_expected(3, 2, 100);
    do_start(3, 2);
    wait_done(d0, 200, ok);
    tick(3);
    n_chk++;
    if (!ok || done_abs - start_cyc + 1 !== 21) begin
      n_fail++;
      $display("FAIL midrun_rerun_done: got %0d (seen=%0b), expected 21", done_abs - start_cyc + 1, ok);
    end
    for (int k = w0; k < wr_cnt; k++) begin
      zexp_t e;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL midrun_rerun_z_extra: addr %0d val %0d, expected no write", obs_addr[k], obs_val[k]);
      end else begin
        e = sb.pop_front();
        if (obs_addr[k] !== e.addr || obs_val[k] !== e.val) begin
          n_fail++;
          $display("FAIL midrun_rerun_z: addr %0d val %0d, expected addr %0d val %0d", obs_addr[k], obs_val[k], e.addr, e.val);
        end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL midrun_rerun_z_missing: %0d writes outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_start_ignored();
    int w0, d0;
    load_basic();
    w0 = wr_cnt; d0 = done_cnt;
    do_start(3, 2);
    tick(4);
    start = 1'b1;
    tick(2);
    start = 1'b0;
    tick(14);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ignored_done_cycle21: done=%b busy=%b, expected 1 1", done, busy);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start_in_done: busy=%b, expected 0", busy);
    end
    tick(3);
    n_chk++;
    if (busy !== 1'b0 || wr_cnt - w0 !== 4 || done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL ignored_totals: busy=%b writes=%0d dones=%0d, expected 0 4 1", busy, wr_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_held_start();
    int w0, d0;
    bit ok;
    xmem[0] = 5;
    ymem[0] = 7;
    w0 = wr_cnt; d0 = done_cnt;
    push_expected(1, 1, 100);
    push_expected(1, 1, 100);
    size_x    = SW'(1);
    size_y    = SW'(1);
    start     = 1'b1;
    start_cyc = cyc + 1;
    tick(5);
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL held_first_done: done=%b at cycle 5, expected 1", done);
    end
    tick(1);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_idle_gap: busy=%b at cycle 6, expected 0", busy);
    end
    tick(1);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL held_reaccept: busy=%b at cycle 7, expected 1", busy);
    end
    start = 1'b0;
    wait_done(d0 + 1, 50, ok);
    tick(3);
    n_chk++;
    if (!ok || done_abs - start_cyc + 1 !== 11) begin
      n_fail++;
      $display("FAIL held_second_done: got %0d (seen=%0b), expected 11", done_abs - start_cyc + 1, ok);
    end
    for (int k = w0; k < wr_cnt; k++) begin
      zexp_t e;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL held_z_extra: addr %0d val %0d, expected no write", obs_addr[k], obs_val[k]);
      end else begin
        e = sb.pop_front();
        if (obs_addr[k] !== e.addr || obs_val[k] !== e.val) begin
          n_fail++;
          $display("FAIL held_z: addr %0d val %0d, expected addr %0d val %0d", obs_addr[k], obs_val[k], e.addr, e.val);
        end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL held_z_missing: %0d writes outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      xmem[k] = 0;
      ymem[k] = 0;
    end
    test_reset();
    test_basic();
    test_single();
    test_zero();
    test_large();
    test_reset_midrun();
    test_start_ignored();
    test_held_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
